// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a valid/ready stream of 32-bit words into big-endian byte writes.
// Optional output checksum[7:0] (running byte sum) is present when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int unsigned WORD_W = 32;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WR0,
        WR1,
        WR2,
        WR3,
        DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   remaining;
    logic [WORD_W-1:0]  word;

    assign s_ready = (state == ACCEPT);

    // Byte outputs are loaded on entry to each WRn state so they line up with mem_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            word      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (word_count != '0) begin
                                ptr       <= base_addr & ALIGN_MASK;
                                remaining <= word_count;
                                busy      <= 1'b1;
                                state     <= ACCEPT;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    ACCEPT: begin
                        if (s_valid) begin
                            word      <= s_data;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= s_data[31:24];
                            state     <= WR0;
                        end
                    end
                    WR0: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr + ADDR_W'(1);
                        mem_wdata <= word[23:16];
                        state     <= WR1;
                    end
                    WR1: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr + ADDR_W'(2);
                        mem_wdata <= word[15:8];
                        state     <= WR2;
                    end
                    WR2: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr + ADDR_W'(3);
                        mem_wdata <= word[7:0];
                        state     <= WR3;
                    end
                    WR3: begin
                        ptr       <= ptr + ADDR_W'(4);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Sum follows the registered write strobe, so the last byte is included by the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == IDLE) && start && !abort) begin
            checksum <= '0;
        end else if (mem_we) begin
            checksum <= checksum + mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cases plus randomized loads against a byte-sequence model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              abort;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] wq[$];
    logic [17:0] act_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Record every byte the loader writes.
    always @(negedge clk) begin
        if (mem_we) act_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits for ACCEPT, idles s_valid for a gap, then presents one word; returns at the WR0 negedge.
    task automatic feed_word(input logic [31:0] w, input int gmin, input int gmax, input bit poke);
        int k = 0;
        int g;
        while (!s_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", s_ready, 1);
        g = int'($urandom_range(gmax, gmin));
        for (int i = 0; i < g; i++) begin
            if (poke && i == 0) begin
                start      = 1'b1;
                base_addr  = ADDR_W'($urandom);
                word_count = CNT_W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            chk("ready_gap", s_ready, 1);
            chk("busy_gap", busy, 1);
        end
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    // Full load of the words in wq; the model is the expected (addr, byte) sequence.
    task automatic do_load(input logic [ADDR_W-1:0] base, input int gmin, input int gmax, input bit poke);
        logic [17:0]       exp_q[$];
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        logic [7:0]        sum;
        int                n;
        n   = wq.size();
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                a = (base & 10'h3FC) + ADDR_W'(4 * i + b);
                d = 8'(wq[i] >> (24 - 8 * b));
                exp_q.push_back({a, d});
                sum = sum + d;
            end
        end
        act_q.delete();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            feed_word(wq[i], gmin, gmax, poke);
            for (int j = 1; j <= 4; j++) begin
                if (j > 1) @(negedge clk);
                chk("we_wr", mem_we, 1);
                chk("ready_wr", s_ready, 0);
                chk("busy_wr", busy, 1);
                chk("done_wr", done, 0);
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("we_done", mem_we, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", checksum, sum);
`endif
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("wr_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk("wr_byte", act_q[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] psum;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        base_addr  = '0;
        word_count = '0;
        #12;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_ready, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single word at address 0
        wq.delete(); wq.push_back(32'h00500093);
        do_load(10'h000, 0, 0, 1'b0);

        // Two words with a 3-cycle stall between them
        wq.delete(); wq.push_back(32'h11223344); wq.push_back(32'hAABBCCDD);
        do_load(10'h010, 3, 3, 1'b0);

        // Unaligned base near the top wraps to 0
        wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
        do_load(10'h3FE, 0, 1, 1'b0);

        // Checksum reference words
        wq.delete(); wq.push_back(32'h01020304); wq.push_back(32'h000000FF);
        do_load(10'h100, 0, 2, 1'b1);

        // Zero count: done next cycle, no write
        act_q.delete();
        @(negedge clk);
        start = 1'b1; word_count = '0; base_addr = 10'h055;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_we", mem_we, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("zero_checksum", checksum, 0);
`endif
        @(negedge clk);
        chk("zero_done_clear", done, 0);
        chk("zero_writes", act_q.size(), 0);

        // Abort together with start in IDLE: nothing begins
        @(negedge clk);
        start = 1'b1; abort = 1'b1; word_count = 9'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abstart_busy", busy, 0);
        chk("abstart_ready", s_ready, 0);
        repeat (3) @(negedge clk);
        chk("abstart_done", done, 0);

        // Abort in WR1: two bytes land, then silence
        wq.delete(); wq.push_back($urandom); wq.push_back($urandom);
        act_q.delete();
        @(negedge clk);
        start = 1'b1; base_addr = 10'h200; word_count = 9'd2;
        @(negedge clk);
        start = 1'b0;
        feed_word(wq[0], 0, 1, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        chk("abort_writes", act_q.size(), 2);
        if (act_q.size() >= 2) begin
            chk("abort_b0", act_q[0], {10'h200, wq[0][31:24]});
            chk("abort_b1", act_q[1], {10'h201, wq[0][23:16]});
        end
        psum = wq[0][31:24] + wq[0][23:16];
`ifdef LOADER_CHECKSUM_EN
        chk("abort_checksum", checksum, psum);
`endif

        // Reset in WR2: outputs clear without a clock edge
        act_q.delete();
        @(negedge clk);
        start = 1'b1; base_addr = 10'h080; word_count = 9'd3;
        @(negedge clk);
        start = 1'b0;
        feed_word($urandom, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", s_ready, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("arst_checksum", checksum, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        chk("arst_writes", act_q.size(), 3);

        // Fresh load after reset, then random loads
        wq.delete(); wq.push_back($urandom);
        do_load(10'h080, 0, 0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            int n;
            n = int'($urandom_range(4, 1));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            do_load(ADDR_W'($urandom), 0, 3, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
